// File: rtl/seg7_scan_driver_if.sv
// Display bus for the 4-digit scan driver: frame value, load strobe and
// scan controls in; anode/segment drive and frame marker out.
interface seg7_scan_driver_if;
    logic [15:0] data;
    logic        data_valid;
    logic [3:0]  dp_mask;
    logic        lz_blank;
    logic        enable;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    modport master (
        output data, data_valid, dp_mask, lz_blank, enable,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  data, data_valid, dp_mask, lz_blank, enable,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode hex display driver with frame-synchronous
// shadow commit, leading-zero blanking and per-slot anti-ghost dead time.
module seg7_scan_driver #(
    parameter int unsigned DIV_CNT   = 50000,
    parameter int unsigned BLANK_CYC = 8
) (
    input  logic                CLK,
    input  logic                clr,
    seg7_scan_driver_if.slave   bus
);

    localparam int unsigned CNT_W  = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
    localparam int unsigned DIG_W  = 2;
    localparam int unsigned NDIG   = 4;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned DATA_W = 16;

    logic [CNT_W-1:0]  r_slot_cnt;
    logic [DIG_W-1:0]  r_digit;
    logic [DATA_W-1:0] r_shadow_data;
    logic [NDIG-1:0]   r_shadow_dp;
    logic              r_pending;
    logic [DATA_W-1:0] r_disp_data;
    logic [NDIG-1:0]   r_disp_dp;
    logic [NDIG-1:0]   r_an;
    logic [SEG_W-1:0]  r_seg;
    logic              r_dp;
    logic              r_frame_done;

    logic              w_slot_wrap;
    logic              w_frame_wrap;
    logic              w_dead;
    logic [NIB_W-1:0]  w_nib;
    logic [NDIG-1:0]   w_zero_above;
    logic              w_lz_hit;
    logic [NDIG-1:0]   w_an;
    logic [SEG_W-1:0]  w_seg;
    logic              w_dp;

    // Active-low gfedcba hex font
    function automatic logic [SEG_W-1:0] hex7(input logic [NIB_W-1:0] n);
        logic [SEG_W-1:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign w_slot_wrap  = (r_slot_cnt == CNT_W'(DIV_CNT - 1));
    assign w_frame_wrap = w_slot_wrap && (r_digit == DIG_W'(NDIG - 1));
    assign w_dead       = (32'(r_slot_cnt) < BLANK_CYC);

    // Slot timer and digit index
    always_ff @(posedge CLK or negedge clr) begin
        if (!clr) begin
            r_slot_cnt <= '0;
            r_digit    <= '0;
        end else if (w_slot_wrap) begin
            r_slot_cnt <= '0;
            r_digit    <= r_digit + DIG_W'(1);
        end else begin
            r_slot_cnt <= r_slot_cnt + CNT_W'(1);
        end
    end

    // Shadow capture; commit only at the frame boundary so a frame never tears.
    // A strobe coincident with the commit writes straight through.
    always_ff @(posedge CLK or negedge clr) begin
        if (!clr) begin
            r_shadow_data <= '0;
            r_shadow_dp   <= '0;
            r_pending     <= 1'b0;
            r_disp_data   <= '0;
            r_disp_dp     <= '0;
        end else begin
            if (bus.data_valid) begin
                r_shadow_data <= bus.data;
                r_shadow_dp   <= bus.dp_mask;
            end
            if (w_frame_wrap) begin
                r_pending <= 1'b0;
                if (bus.data_valid) begin
                    r_disp_data <= bus.data;
                    r_disp_dp   <= bus.dp_mask;
                end else if (r_pending) begin
                    r_disp_data <= r_shadow_data;
                    r_disp_dp   <= r_shadow_dp;
                end
            end else if (bus.data_valid) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign w_nib = r_disp_data[{r_digit, 2'b00} +: NIB_W];

    // Digit k is a leading zero when it and every higher nibble are zero
    always_comb begin
        w_zero_above    = '0;
        w_zero_above[3] = (r_disp_data[15:12] == 4'h0);
        w_zero_above[2] = w_zero_above[3] && (r_disp_data[11:8] == 4'h0);
        w_zero_above[1] = w_zero_above[2] && (r_disp_data[7:4] == 4'h0);
        w_lz_hit        = bus.lz_blank && w_zero_above[r_digit];
    end

    always_comb begin
        w_an  = '1;
        w_seg = '1;
        w_dp  = 1'b1;
        if (bus.enable && !w_dead) begin
            w_an  = ~(NDIG'(1) << r_digit);
            w_seg = w_lz_hit ? '1 : hex7(w_nib);
            w_dp  = ~r_disp_dp[r_digit];
        end
    end

    always_ff @(posedge CLK or negedge clr) begin
        if (!clr) begin
            r_an         <= '1;
            r_seg        <= '1;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= w_an;
            r_seg        <= w_seg;
            r_dp         <= w_dp;
            r_frame_done <= w_frame_wrap;
        end
    end

    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.dp         = r_dp;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIV_CNT=4, BLANK_CYC=1 (16-cycle frame).
module tb_seg7_scan_driver;

    localparam logic [6:0] S_0  = 7'b1000000;
    localparam logic [6:0] S_1  = 7'b1111001;
    localparam logic [6:0] S_2  = 7'b0100100;
    localparam logic [6:0] S_3  = 7'b0110000;
    localparam logic [6:0] S_4  = 7'b0011001;
    localparam logic [6:0] S_5  = 7'b0010010;
    localparam logic [6:0] S_8  = 7'b0000000;
    localparam logic [6:0] S_A  = 7'b0001000;
    localparam logic [6:0] S_C  = 7'b1000110;
    localparam logic [6:0] S_E  = 7'b0000110;
    localparam logic [6:0] S_F  = 7'b0001110;
    localparam logic [6:0] S_BL = 7'b1111111;

    typedef struct {
        logic [15:0]     data;
        logic [3:0]      mask;
        logic            lz;
        logic [3:0][6:0] seg;   // expected seg per digit, [3] = digit 3
        logic [3:0]      dpn;   // expected active-low dp per digit
    } vec_t;

    logic clk;
    logic clr;
    int   checks;
    int   errors;

    seg7_scan_driver_if u_if();

    seg7_scan_driver #(.DIV_CNT(4), .BLANK_CYC(1)) u_dut (
        .CLK (clk),
        .clr (clr),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_rst(input string tag);
        checks++;
        if ({u_if.an, u_if.seg, u_if.dp, u_if.frame_done} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL %s: an=%b seg=%b dp=%b fd=%b want an=1111 seg=1111111 dp=1 fd=0",
                     tag, u_if.an, u_if.seg, u_if.dp, u_if.frame_done);
        end
    endtask

    // Sample i (1..) counts cycles after the frame_done sample; slot 0 of each digit is dead time
    task automatic check_slot(input string tag, input int i, input logic [3:0][6:0] es,
                              input logic [3:0] edp, input logic lit_en);
        int d;
        int s;
        logic [3:0] ean;
        logic [6:0] eseg;
        logic       edp1;
        logic       efd;
        d    = ((i - 1) / 4) % 4;
        s    = (i - 1) % 4;
        ean  = 4'b1111;
        eseg = S_BL;
        edp1 = 1'b1;
        efd  = (i == 16);
        if (lit_en && s != 0) begin
            ean  = ~(4'b0001 << d);
            eseg = es[d];
            edp1 = edp[d];
        end
        checks++;
        if ({u_if.an, u_if.seg, u_if.dp, u_if.frame_done} !== {ean, eseg, edp1, efd}) begin
            errors++;
            $display("FAIL %s cyc %0d: an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                     tag, i, u_if.an, u_if.seg, u_if.dp, u_if.frame_done, ean, eseg, edp1, efd);
        end
    endtask

    task automatic wait_fd(input string tag);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            u_if.data_valid = 1'b0;
            if (u_if.frame_done === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s: frame_done=0 after 40 cycles, want a pulse", tag);
        end
    endtask

    // One whole frame from a frame_done sample to the next, optionally strobing a load
    task automatic walk(input string tag, input logic [3:0][6:0] es, input logic [3:0] edp,
                        input int strobe_at, input logic [15:0] sd, input logic [3:0] sm);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            u_if.data_valid = 1'b0;
            check_slot(tag, i, es, edp, 1'b1);
            if (i == strobe_at) begin
                u_if.data       = sd;
                u_if.dp_mask    = sm;
                u_if.data_valid = 1'b1;
            end
        end
    endtask

    vec_t vecs[6];
    logic [3:0][6:0] prev_seg;
    logic [3:0]      prev_dpn;
    logic [3:0][6:0] zeros_seg;
    logic [3:0][6:0] threes_seg;

    initial begin
        checks = 0;
        errors = 0;
        zeros_seg  = {S_0, S_0, S_0, S_0};
        threes_seg = {S_3, S_3, S_3, S_3};
        vecs[0] = '{16'h12AF, 4'b0100, 1'b0, {S_1, S_2, S_A, S_F}, 4'b1011};
        vecs[1] = '{16'h0030, 4'b0000, 1'b1, {S_BL, S_BL, S_3, S_0}, 4'b1111};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, {S_BL, S_BL, S_BL, S_0}, 4'b1111};
        vecs[3] = '{16'h8E5C, 4'b1010, 1'b0, {S_8, S_E, S_5, S_C}, 4'b0101};
        vecs[4] = '{16'h0405, 4'b0001, 1'b1, {S_BL, S_4, S_0, S_5}, 4'b1110};
        vecs[5] = '{16'h0000, 4'b0000, 1'b0, {S_0, S_0, S_0, S_0}, 4'b1111};

        clr             = 1'b0;
        u_if.data       = '0;
        u_if.data_valid = 1'b0;
        u_if.dp_mask    = '0;
        u_if.lz_blank   = 1'b0;
        u_if.enable     = 1'b1;
        repeat (3) @(negedge clk);
        check_rst("reset");
        clr = 1'b1;

        // Power-on frame shows 0000 with no load
        wait_fd("first_fd");
        walk("idle", zeros_seg, 4'b1111, 0, '0, '0);
        prev_seg = zeros_seg;
        prev_dpn = 4'b1111;

        // Mid-frame load: current frame keeps old value, next frame shows new
        for (int v = 0; v < 6; v++) begin
            walk("old_frame", prev_seg, prev_dpn, 6, vecs[v].data, vecs[v].mask);
            u_if.lz_blank = vecs[v].lz;
            walk("new_frame", vecs[v].seg, vecs[v].dpn, 0, '0, '0);
            prev_seg = vecs[v].seg;
            prev_dpn = vecs[v].dpn;
        end

        // Back-to-back strobes, last one coincident with the commit edge
        u_if.lz_blank = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            u_if.data_valid = 1'b0;
            check_slot("b2b_old", i, zeros_seg, 4'b1111, 1'b1);
            if (i == 3 || i == 8 || i == 15) begin
                u_if.data       = (i == 3) ? 16'h1111 : (i == 8) ? 16'h2222 : 16'h3333;
                u_if.dp_mask    = 4'b0000;
                u_if.data_valid = 1'b1;
            end
        end
        walk("wthru", threes_seg, 4'b1111, 0, '0, '0);
        walk("wthru_hold", threes_seg, 4'b1111, 0, '0, '0);

        // enable=0 for 20 cycles: anodes off, frame_done keeps its period
        u_if.enable = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            check_slot("enable", i, threes_seg, 4'b1111, (i > 20));
            if (i == 20) u_if.enable = 1'b1;
        end

        // Reset mid-slot of digit 2 with a pending load
        wait_fd("pre_rst_fd");
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            u_if.data_valid = 1'b0;
            check_slot("pre_rst", i, threes_seg, 4'b1111, 1'b1);
            if (i == 2) begin
                u_if.data       = 16'hBEEF;
                u_if.dp_mask    = 4'b1111;
                u_if.data_valid = 1'b1;
            end
        end
        #2 clr = 1'b0;
        #1 check_rst("rst_async");
        repeat (2) begin
            @(negedge clk);
            check_rst("rst_hold");
        end
        clr = 1'b1;
        wait_fd("post_rst_fd");
        walk("post_rst", zeros_seg, 4'b1111, 0, '0, '0);
        walk("post_rst2", zeros_seg, 4'b1111, 0, '0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
